// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the sequence generator and its receive-side checker.
package lfsr_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MAX_WIDTH     = 64;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_t;

  // Operates at MAX_WIDTH so any narrower WIDTH can zero-extend in and truncate out;
  // the zero upper bits leave the feedback parity unchanged.
  function automatic logic [MAX_WIDTH-1:0] step(input logic [MAX_WIDTH-1:0] s,
                                                input logic [MAX_WIDTH-1:0] taps);
    return {s[MAX_WIDTH-2:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc yields 1.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: self-synchronises to an lfsr word stream, then flywheels and counts mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int unsigned LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;

  chk_state_t       state;
  logic [WIDTH-1:0] pred;
  logic [MW-1:0]    match_cnt;
  logic [LW-1:0]    miss_cnt;
  logic [WIDTH-1:0] step_in;
  logic [WIDTH-1:0] step_pred;
  logic             err_inc;

  always_comb begin
    step_in   = WIDTH'(step(MAX_WIDTH'(data_in), MAX_WIDTH'(taps)));
    step_pred = WIDTH'(step(MAX_WIDTH'(pred), MAX_WIDTH'(taps)));
    err_inc   = enable && (state == LOCKED) && (data_in != pred);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (enable) begin
        case (state)
          HUNT: begin
            if (data_in != '0) begin
              pred      <= step_in;
              match_cnt <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (data_in == pred) begin
              pred <= step_in;
              if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                miss_cnt  <= '0;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else if (data_in != '0) begin
              pred      <= step_in;
              match_cnt <= '0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: the prediction advances from itself, never from received data.
            pred <= step_pred;
            if (data_in == pred) begin
              miss_cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (miss_cnt == LW'(LOSS_COUNT - 1)) begin
                state  <= HUNT;
                locked <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + LW'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_inc),
    .clear(clear_count),
    .count(err_count)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a CNT_W=4/LOSS_COUNT=32 instance.
module tb_lfsr_checker;

  localparam logic [7:0] TAPS = 8'b10001110;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  taps;
  logic [7:0]  data_in;
  logic        clear_count;
  logic        locked,  err_pulse;
  logic [15:0] err_count;
  logic        locked2, err_pulse2;
  logic [3:0]  err_count2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lfsr_checker #(
    .WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .taps(taps), .data_in(data_in),
    .clear_count(clear_count), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  lfsr_checker #(
    .WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(32), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .taps(taps), .data_in(data_in),
    .clear_count(clear_count), .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: feedback is the XOR of the state bits selected by TAPS.
  function automatic logic [7:0] nxt(input logic [7:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) if (TAPS[i]) fb ^= s[i];
    return {s[6:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic en, input logic [7:0] d, input logic clr);
    enable      = en;
    data_in     = d;
    clear_count = clr;
    @(posedge clk);
    #1;
    enable      = 1'b0;
    clear_count = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst_n = 1'b0; enable = 1'b0; data_in = '0; taps = TAPS; clear_count = 1'b0;
    #12;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Lock-up word is ignored in HUNT
    for (int k = 0; k < 3; k++) drive(1'b1, 8'h00, 1'b0);
    chk("hunt_zero_locked", 32'(locked), 32'd0);

    // Clean stream from 0x01: lock at the 5th word
    w = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, w, 1'b0);
      w = nxt(w);
      chk("lock_rise", 32'(locked), (k == 5) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, w, 1'b0);
      w = nxt(w);
      chk("clean_pulse", 32'(err_pulse), 32'd0);
    end
    chk("clean_count", 32'(err_count), 32'd0);
    chk("clean_locked", 32'(locked), 32'd1);

    // Single corrupted word while locked
    drive(1'b1, w ^ 8'h01, 1'b0);
    w = nxt(w);
    chk("err1_pulse", 32'(err_pulse), 32'd1);
    chk("err1_count", 32'(err_count), 32'd1);
    chk("err1_locked", 32'(locked), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, w, 1'b0);
      w = nxt(w);
      chk("after_err_pulse", 32'(err_pulse), 32'd0);
      chk("after_err_count", 32'(err_count), 32'd1);
    end

    // Stall: garbage on data_in with enable low must be ignored
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'hA5, 1'b0);
      chk("stall_pulse", 32'(err_pulse), 32'd0);
      chk("stall_count", 32'(err_count), 32'd1);
    end
    drive(1'b1, w, 1'b0);
    w = nxt(w);
    chk("resume_pulse", 32'(err_pulse), 32'd0);
    chk("resume_count", 32'(err_count), 32'd1);
    chk("resume_locked", 32'(locked), 32'd1);

    // Clear without error, then four mismatches drop lock
    drive(1'b1, w, 1'b1);
    w = nxt(w);
    chk("clear_count", 32'(err_count), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, ~w, 1'b0);
      w = nxt(w);
      chk("loss_pulse", 32'(err_pulse), 32'd1);
      chk("loss_count", 32'(err_count), 32'(k));
      chk("loss_locked", 32'(locked), (k < 4) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'h00, 1'b0);
      chk("zero_hunt_locked", 32'(locked), 32'd0);
      chk("zero_hunt_pulse", 32'(err_pulse), 32'd0);
    end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, w, 1'b0);
      w = nxt(w);
      chk("relock", 32'(locked), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("relock_count", 32'(err_count), 32'd4);

    // Asynchronous reset mid-cycle while locked
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_locked", 32'(locked), 32'd0);
    chk("async_rst_pulse", 32'(err_pulse), 32'd0);
    chk("async_rst_count", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, w, 1'b0);
      chk("post_rst_locked", 32'(locked), 32'd0);
    end

    // Saturation on the narrow instance
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, w, 1'b0);
      w = nxt(w);
      chk("lock2", 32'(locked2), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("lock2_count", 32'(err_count2), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, ~w, 1'b0);
      w = nxt(w);
      chk("sat_count", 32'(err_count2), (k > 15) ? 32'd15 : 32'(k));
      chk("sat_locked", 32'(locked2), 32'd1);
    end
    drive(1'b1, ~w, 1'b1);
    w = nxt(w);
    chk("clear_inc_count", 32'(err_count2), 32'd1);
    chk("clear_inc_pulse", 32'(err_pulse2), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
